axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

Shares the single AXI4 write channel (AW/W/B) between two local requesters, one burst at a time, with round-robin fairness. Captures each requester's burst descriptor, drives AW with fixed INCR/64-bit attributes, steers the granted requester's write data onto W with generated `wlast`, and returns the B response as a one-cycle completion pulse. Sits between the DMA/producer engines and the AXI4 master port of the top level.

## Interface
- `ADDR_W`, 32, address width of `awaddr` and `rqN_addr`.
- `DATA_W`, 64, data width; `wstrb` is `DATA_W/8`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rq0_valid` / `rq1_valid`  in  1  requester N has a burst pending; held until `rqN_ready`.
- `rq0_ready` / `rq1_ready`  out  1  one-cycle pulse: descriptor captured.
- `rq0_addr` / `rq1_addr`  in  ADDR_W  burst start address, 8-byte aligned.
- `rq0_len` / `rq1_len`  in  8  AXI beats minus one.
- `rq0_wdata`, `rq1_wdata`  in  DATA_W; `rq0_wstrb`, `rq1_wstrb`  in  DATA_W/8; `rq0_wvalid`, `rq1_wvalid`  in  1: write data stream.
- `rq0_wready` / `rq1_wready`  out  1  data accepted.
- `rq0_done` / `rq1_done`  out  1  one-cycle completion pulse.
- `rq0_resp` / `rq1_resp`  out  2  response, valid with `done`.
- AXI master: `awid`[1:0], `awaddr`[ADDR_W], `awlen`[8], `awsize`[3], `awburst`[2], `awlock`, `awcache`[4], `awprot`[3], `awvalid` out; `awready` in; `wdata`, `wstrb`, `wlast`, `wvalid` out; `wready` in; `bid`[1:0], `bresp`[2], `bvalid` in; `bready` out.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Only one burst outstanding.
- IDLE: if any `rqN_valid`, grant: only one requesting gets it; both requesting gets the one not granted last (`last_gnt` resets to 1, so rq0 wins first). Register addr, len, grant index; pulse `rqN_ready`; -> ADDR.
- ADDR: `awvalid`=1, `awid`={1'b0,gnt}, `awaddr`/`awlen` from captured descriptor. On `awready` -> DATA, beat counter loaded with len.
- Constant attributes: `awsize`=3'b011, `awburst`=2'b01 INCR, `awlock`=0, `awcache`=4'b0011, `awprot`=3'b000.
- DATA: `wdata`/`wstrb`/`wvalid` muxed from granted requester; `rqGNT_wready`=`wready`; non-granted `wready`=0. `wlast`=1 when counter==0. Counter decrements on `wvalid & wready`; accepted beat with `wlast` -> RESP.
- RESP: `bready`=1. On `bvalid`: `rqGNT_resp`=`bresp`, except `bid`!=`awid` forces 2'b10 (SLVERR); `rqGNT_done` pulses next cycle; `last_gnt`=gnt; -> IDLE.
- W data is never presented before AW handshake completes.
- len=0: single beat, `wlast` high on first beat.

## Timing
- Reset values: all `rqN_ready`, `rqN_wready`, `rqN_done`=0, `rqN_resp`=0, `awvalid`=0, `wvalid`=0, `wlast`=0, `bready`=0, `awaddr`/`awlen`/`awid`=0; attributes at constants; state IDLE.
- `rqN_valid` seen in IDLE at cycle T: `rqN_ready` high in T+1, `awvalid` high from T+1; `awvalid` and AW fields stable until `awready`.
- Earliest W beat: cycle after AW handshake. `wvalid` combinational from granted requester in DATA (no added latency, no buffering).
- `done` one cycle after B handshake; state is IDLE in the same cycle, so the next grant's `ready` can occur the following cycle (min 1 idle cycle between bursts).
- `rqN_valid` dropped before grant: ignored, no side effect.
- `rst` asserted mid-burst: immediate return to IDLE, all outputs to reset values, no `done` issued; interconnect must be reset concurrently.

## Test plan
- Single rq0 burst addr=0x1000 len=3: one AW (awid=0, awlen=3, awsize=3, awburst=1), 4 W beats with `wlast` only on 4th, bresp=0 -> `rq0_done` one pulse with resp=0.
- Both valid continuously, len=0 each: grants alternate rq0, rq1, rq0, rq1; awid sequence 0,1,0,1; no `rq1_wready` during rq0 burst.
- `awready` held low 5 cycles, `wready` toggling 1-0-1: AW fields stable, beats counted only on handshake, exactly len+1 beats.
- B returns bid=1 for an awid=0 burst with bresp=0 -> `rq0_resp`=2'b10; bresp=2'b11 with matching bid -> resp=2'b11.
- `rst` pulsed during DATA after 2 of 8 beats: all outputs at reset values next edge, no `done`; a fresh rq1 request afterwards completes normally with rq0 priority restored.

Source files
------------

// File: rtl/axi_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW/W/B) between the arbiter (master) and the interconnect (slave).
// Every channel transfers on a rising edge where valid && ready; the valid side holds its payload stable until then.
interface axi_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [1:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write channel between two requesters, one burst at a time.
// The captured descriptor lives directly in the AW registers; W is a zero-latency mux of the granted requester.
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rq0_valid,
  input  logic                rq1_valid,
  output logic                rq0_ready,
  output logic                rq1_ready,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [7:0]          rq0_len,
  input  logic [7:0]          rq1_len,
  input  logic [DATA_W-1:0]   rq0_wdata,
  input  logic [DATA_W-1:0]   rq1_wdata,
  input  logic [DATA_W/8-1:0] rq0_wstrb,
  input  logic [DATA_W/8-1:0] rq1_wstrb,
  input  logic                rq0_wvalid,
  input  logic                rq1_wvalid,
  output logic                rq0_wready,
  output logic                rq1_wready,
  output logic                rq0_done,
  output logic                rq1_done,
  output logic [1:0]          rq0_resp,
  output logic [1:0]          rq1_resp,
  output logic [1:0]          state_dbg,
  axi_wr_arbiter_if.master    axi
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  state_t     state;
  logic       gnt;
  logic       last_gnt;
  logic       gnt_next;
  logic [7:0] cnt;
  logic       beat_hs;
  logic [1:0] b_code;

  assign state_dbg = state;

  assign axi.awsize  = 3'b011;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = 3'b000;

  // With both requesting, the side that did not win last time takes the grant.
  always_comb begin
    gnt_next = 1'b0;
    if (rq0_valid && rq1_valid) gnt_next = ~last_gnt;
    else if (rq1_valid)         gnt_next = 1'b1;
  end

  always_comb begin
    axi.wvalid = (state == DATA) && (gnt ? rq1_wvalid : rq0_wvalid);
    axi.wdata  = gnt ? rq1_wdata : rq0_wdata;
    axi.wstrb  = gnt ? rq1_wstrb : rq0_wstrb;
    axi.wlast  = (state == DATA) && (cnt == 8'd0);
    rq0_wready = (state == DATA) && !gnt && axi.wready;
    rq1_wready = (state == DATA) &&  gnt && axi.wready;
    beat_hs    = axi.wvalid && axi.wready;
    b_code     = (axi.bid != axi.awid) ? 2'b10 : axi.bresp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      cnt         <= 8'd0;
      rq0_ready   <= 1'b0;
      rq1_ready   <= 1'b0;
      rq0_done    <= 1'b0;
      rq1_done    <= 1'b0;
      rq0_resp    <= 2'b00;
      rq1_resp    <= 2'b00;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awlen   <= 8'd0;
      axi.awid    <= 2'b00;
      axi.bready  <= 1'b0;
    end else begin
      rq0_ready <= 1'b0;
      rq1_ready <= 1'b0;
      rq0_done  <= 1'b0;
      rq1_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (rq0_valid || rq1_valid) begin
            gnt         <= gnt_next;
            axi.awaddr  <= gnt_next ? rq1_addr : rq0_addr;
            axi.awlen   <= gnt_next ? rq1_len : rq0_len;
            axi.awid    <= {1'b0, gnt_next};
            axi.awvalid <= 1'b1;
            rq0_ready   <= ~gnt_next;
            rq1_ready   <= gnt_next;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
            cnt         <= axi.awlen;
            state       <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd0) begin
              axi.bready <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            last_gnt   <= gnt;
            if (gnt) begin
              rq1_done <= 1'b1;
              rq1_resp <= b_code;
            end else begin
              rq0_done <= 1'b1;
              rq0_resp <= b_code;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: expected AW/W/done records are queued when stimulus is issued,
// and a negedge monitor pops and compares them whenever the DUT presents a transfer.
module tb_axi_wr_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int AW_W   = 2 + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3;
  localparam int WB_W   = 1 + DATA_W / 8 + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              rq_valid  [2];
  logic [ADDR_W-1:0] rq_addr   [2];
  logic [7:0]        rq_len    [2];
  logic [DATA_W-1:0] rq_wdata  [2];
  logic [7:0]        rq_wstrb  [2];
  logic              rq_wvalid [2];
  logic [1:0]        rq_ready;
  logic [1:0]        rq_wready;
  logic [1:0]        rq_done;
  logic [1:0]        rq0_resp;
  logic [1:0]        rq1_resp;
  logic [1:0]        state_dbg;

  axi_wr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq0_valid  (rq_valid[0]),
    .rq1_valid  (rq_valid[1]),
    .rq0_ready  (rq_ready[0]),
    .rq1_ready  (rq_ready[1]),
    .rq0_addr   (rq_addr[0]),
    .rq1_addr   (rq_addr[1]),
    .rq0_len    (rq_len[0]),
    .rq1_len    (rq_len[1]),
    .rq0_wdata  (rq_wdata[0]),
    .rq1_wdata  (rq_wdata[1]),
    .rq0_wstrb  (rq_wstrb[0]),
    .rq1_wstrb  (rq_wstrb[1]),
    .rq0_wvalid (rq_wvalid[0]),
    .rq1_wvalid (rq_wvalid[1]),
    .rq0_wready (rq_wready[0]),
    .rq1_wready (rq_wready[1]),
    .rq0_done   (rq_done[0]),
    .rq1_done   (rq_done[1]),
    .rq0_resp   (rq0_resp),
    .rq1_resp   (rq1_resp),
    .state_dbg  (state_dbg),
    .axi        (axi.master)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [AW_W-1:0] exp_aw_q[$];
  logic [WB_W-1:0] exp_w_q[$];
  logic [2:0]      exp_done_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name, input logic [127:0] act);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  task automatic push_aw(input logic [1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    exp_aw_q.push_back({id, addr, len, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
  endtask

  task automatic push_w(input logic [DATA_W-1:0] base, input int len);
    for (int b = 0; b <= len; b++)
      exp_w_q.push_back({(b == len), 8'hF0 | 8'(b % 16), base + 64'(b)});
  endtask

  task automatic push_done(input logic idx, input logic [1:0] resp);
    exp_done_q.push_back({idx, resp});
  endtask

  // ---------------- slave model / config ----------------
  int         aw_delay  = 0;
  logic       w_toggle  = 1'b0;
  logic       bid_bad   = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  logic       w_last_seen = 1'b0;
  int         beats_seen  = 0;

  initial begin
    int aw_wait;
    logic wphase;
    logic [1:0] awid_cap;
    aw_wait = 0; wphase = 1'b0; awid_cap = 2'b00;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    axi.bid = 2'b00; axi.bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        aw_wait = 0; wphase = 1'b0; w_last_seen = 1'b0;
        continue;
      end
      if (axi.awvalid) begin
        axi.awready = (aw_wait >= aw_delay);
        awid_cap = axi.awid;
        aw_wait++;
      end else begin
        axi.awready = 1'b0;
        aw_wait = 0;
      end
      wphase = ~wphase;
      axi.wready = w_toggle ? wphase : 1'b1;
      if (axi.bvalid && !axi.bready) axi.bvalid = 1'b0;
      if (w_last_seen) begin
        w_last_seen = 1'b0;
        axi.bvalid = 1'b1;
        axi.bid = bid_bad ? (awid_cap ^ 2'b01) : awid_cap;
        axi.bresp = bresp_cfg;
      end
    end
  end

  // ---------------- monitor ----------------
  function automatic logic [AW_W-1:0] aw_fields();
    return {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot};
  endfunction

  initial begin
    int cyc;
    int b_cycle;
    logic prev_awvalid, prev_awready;
    logic [AW_W-1:0] prev_aw;
    logic [2:0] d;
    cyc = 0; b_cycle = -10; prev_awvalid = 1'b0; prev_awready = 1'b0; prev_aw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_awvalid = 1'b0;
      end else begin
        if (axi.awvalid && prev_awvalid && !prev_awready)
          check("aw_stable", aw_fields(), prev_aw);
        if (axi.awvalid && axi.awready) begin
          if (exp_aw_q.size() == 0) miss("aw_extra", aw_fields());
          else check("aw", aw_fields(), exp_aw_q.pop_front());
        end
        if (axi.wvalid) check("w_before_aw", axi.awvalid, 1'b0);
        if (axi.wvalid && axi.wready) begin
          beats_seen++;
          if (axi.wlast) w_last_seen = 1'b1;
          if (exp_w_q.size() == 0) miss("w_extra", {axi.wlast, axi.wstrb, axi.wdata});
          else check("w", {axi.wlast, axi.wstrb, axi.wdata}, exp_w_q.pop_front());
        end
        if (rq_wready[0]) check("wready_owner0", axi.awid, 2'd0);
        if (rq_wready[1]) check("wready_owner1", axi.awid, 2'd1);
        if (axi.bvalid && axi.bready) b_cycle = cyc;
        for (int i = 0; i < 2; i++) begin
          if (rq_done[i]) begin
            check("done_timing", cyc, b_cycle + 1);
            d = {i[0], (i == 0) ? rq0_resp : rq1_resp};
            if (exp_done_q.size() == 0) miss("done_extra", d);
            else check("done", d, exp_done_q.pop_front());
          end
        end
        prev_awvalid = axi.awvalid;
        prev_awready = axi.awready;
        prev_aw = aw_fields();
      end
      cyc++;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_rq(input int idx, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                        input logic [DATA_W-1:0] base);
    int t;
    int beat;
    logic hs;
    rq_valid[idx] = 1'b1;
    rq_addr[idx]  = addr;
    rq_len[idx]   = len;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!rq_ready[idx] && !rst && t < 200);
    rq_valid[idx] = 1'b0;
    if (rst) return;
    if (!rq_ready[idx]) begin
      miss("rq_ready_timeout", idx);
      return;
    end
    beat = 0;
    t = 0;
    while (beat <= int'(len) && t < 200) begin
      rq_wvalid[idx] = 1'b1;
      rq_wdata[idx]  = base + 64'(beat);
      rq_wstrb[idx]  = 8'hF0 | 8'(beat % 16);
      @(negedge clk);
      hs = rq_wready[idx];
      @(posedge clk); #1;
      if (rst) break;
      if (hs) beat++;
      t++;
    end
    rq_wvalid[idx] = 1'b0;
    if (!rst && beat <= int'(len)) miss("wdata_timeout", beat);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_aw_q.size() + exp_w_q.size() + exp_done_q.size()) != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) miss(name, exp_aw_q.size() + exp_w_q.size() + exp_done_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    check({name, "_outs"},
          {rq_ready, rq_wready, rq_done, rq0_resp, rq1_resp, axi.awvalid, axi.wvalid,
           axi.wlast, axi.bready, axi.awaddr, axi.awlen, axi.awid, state_dbg}, '0);
    check({name, "_attr"}, {axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
          {3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    miss("watchdog", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rq_valid[i] = 1'b0; rq_addr[i] = '0; rq_len[i] = 8'd0;
      rq_wdata[i] = '0; rq_wstrb[i] = 8'd0; rq_wvalid[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Both requesting continuously, single-beat bursts: rq0, rq1, rq0, rq1.
    push_aw(2'd0, 32'h0000_2000, 8'd0); push_w(64'hA000, 0);
    push_aw(2'd1, 32'h0000_3000, 8'd0); push_w(64'hB000, 0);
    push_aw(2'd0, 32'h0000_2008, 8'd0); push_w(64'hA100, 0);
    push_aw(2'd1, 32'h0000_3008, 8'd0); push_w(64'hB100, 0);
    push_done(1'b0, 2'b00); push_done(1'b1, 2'b00);
    push_done(1'b0, 2'b00); push_done(1'b1, 2'b00);
    fork
      begin
        run_rq(0, 32'h0000_2000, 8'd0, 64'hA000);
        run_rq(0, 32'h0000_2008, 8'd0, 64'hA100);
      end
      begin
        run_rq(1, 32'h0000_3000, 8'd0, 64'hB000);
        run_rq(1, 32'h0000_3008, 8'd0, 64'hB100);
      end
    join
    wait_idle("alternate_idle");

    // Single rq0 four-beat burst.
    push_aw(2'd0, 32'h0000_1000, 8'd3); push_w(64'h1111_0000, 3); push_done(1'b0, 2'b00);
    run_rq(0, 32'h0000_1000, 8'd3, 64'h1111_0000);
    wait_idle("single_idle");

    // Slow AW acceptance and toggling wready.
    aw_delay = 5; w_toggle = 1'b1;
    push_aw(2'd1, 32'h0000_4000, 8'd2); push_w(64'h4444_0000, 2); push_done(1'b1, 2'b00);
    run_rq(1, 32'h0000_4000, 8'd2, 64'h4444_0000);
    wait_idle("stall_idle");
    aw_delay = 0; w_toggle = 1'b0;

    // Mismatched bid forces SLVERR.
    bid_bad = 1'b1;
    push_aw(2'd0, 32'h0000_5000, 8'd1); push_w(64'h5555_0000, 1); push_done(1'b0, 2'b10);
    run_rq(0, 32'h0000_5000, 8'd1, 64'h5555_0000);
    wait_idle("bid_idle");
    bid_bad = 1'b0;

    // DECERR passed through with matching bid.
    bresp_cfg = 2'b11;
    push_aw(2'd0, 32'h0000_6000, 8'd0); push_w(64'h6666_0000, 0); push_done(1'b0, 2'b11);
    run_rq(0, 32'h0000_6000, 8'd0, 64'h6666_0000);
    wait_idle("bresp_idle");
    bresp_cfg = 2'b00;

    // Reset during an 8-beat rq0 burst after two beats; no done may follow.
    beats_seen = 0;
    push_aw(2'd0, 32'h0000_7000, 8'd7); push_w(64'h7777_0000, 7);
    fork
      run_rq(0, 32'h0000_7000, 8'd7, 64'h7777_0000);
    join_none
    for (int t = 0; t < 300 && beats_seen < 2; t++) begin
      @(negedge clk); #1;
    end
    if (beats_seen < 2) miss("mid_reset_beats", beats_seen);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #2;
    check_reset("mid_reset");
    exp_w_q.delete();
    exp_aw_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait fork;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", {rq_done, state_dbg}, 4'b0000);

    // After reset rq0 wins a tie again, then rq1 completes normally.
    push_aw(2'd0, 32'h0000_9000, 8'd0); push_w(64'h9999_0000, 0);
    push_aw(2'd1, 32'h0000_8000, 8'd1); push_w(64'h8888_0000, 1);
    push_done(1'b0, 2'b00); push_done(1'b1, 2'b00);
    fork
      run_rq(1, 32'h0000_8000, 8'd1, 64'h8888_0000);
      run_rq(0, 32'h0000_9000, 8'd0, 64'h9999_0000);
    join
    wait_idle("post_reset_idle");

    check("queues_empty", exp_aw_q.size() + exp_w_q.size() + exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
